// File: rtl/knn_query_ctrl.sv
// knn_query_ctrl: runs one KNN query end to end -- clear the top-K buffer, stream credit-limited
// distance requests, pre-filter responses into the buffer, then drain the buffer in rank order.
module knn_query_ctrl #(
  parameter int DIST_WIDTH  = 16,
  parameter int IDX_WIDTH   = 16,
  parameter int K           = 8,
  parameter int MAX_OUT     = 4,
  parameter int ALPHA_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IDX_WIDTH-1:0]  num_points,
  output logic                  busy,
  output logic                  done,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [IDX_WIDTH-1:0]  req_idx,
  input  logic                  rsp_valid,
  input  logic [DIST_WIDTH-1:0] rsp_distance,
  input  logic [IDX_WIDTH-1:0]  rsp_idx,
  output logic                  topk_clear,
  output logic                  topk_valid,
  output logic [DIST_WIDTH-1:0] topk_dist,
  output logic [IDX_WIDTH-1:0]  topk_idx,
  input  logic [DIST_WIDTH-1:0] threshold,
  output logic [DIST_WIDTH-1:0] running_mean,
  output logic [$clog2(K)-1:0]  topk_rd_sel,
  input  logic                  topk_rd_vld,
  input  logic [DIST_WIDTH-1:0] topk_rd_dist,
  input  logic [IDX_WIDTH-1:0]  topk_rd_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIST_WIDTH-1:0] out_dist,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [$clog2(K)-1:0]  out_rank,
  output logic [IDX_WIDTH-1:0]  pruned_cnt
);
  localparam int SEL_W  = $clog2(K);
  localparam int CRED_W = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_q,   state_d;
  logic [IDX_WIDTH-1:0]  npts_q,    npts_d;
  logic [IDX_WIDTH-1:0]  req_idx_q, req_idx_d;
  logic [IDX_WIDTH-1:0]  rsp_cnt_q, rsp_cnt_d;
  logic [CRED_W-1:0]     credits_q, credits_d;
  logic [DIST_WIDTH-1:0] mean_q,    mean_d;
  logic [IDX_WIDTH-1:0]  pruned_q,  pruned_d;
  logic                  tk_vld_q,  tk_vld_d;
  logic [DIST_WIDTH-1:0] tk_dist_q, tk_dist_d;
  logic [IDX_WIDTH-1:0]  tk_idx_q,  tk_idx_d;
  logic [SEL_W-1:0]      rd_sel_q,  rd_sel_d;

  logic                  req_fire;
  logic                  rsp_fire;
  logic signed [DIST_WIDTH:0] diff_s;
  logic signed [DIST_WIDTH:0] step_s;
  logic signed [DIST_WIDTH:0] sum_s;
  logic [DIST_WIDTH-1:0] mean_upd;

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign topk_clear   = (state_q == S_CLEAR);
  assign req_valid    = (state_q == S_STREAM) && (req_idx_q < npts_q) && (credits_q != '0);
  assign req_idx      = req_idx_q;
  assign topk_valid   = tk_vld_q;
  assign topk_dist    = tk_dist_q;
  assign topk_idx     = tk_idx_q;
  assign running_mean = mean_q;
  assign pruned_cnt   = pruned_q;
  assign topk_rd_sel  = rd_sel_q;
  assign out_valid    = (state_q == S_DRAIN) && topk_rd_vld;
  assign out_dist     = topk_rd_dist;
  assign out_idx      = topk_rd_idx;
  assign out_rank     = rd_sel_q;

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = (state_q == S_STREAM) && rsp_valid;

  // EMA step in a signed width one bit wider than the distance; the true result lies between
  // the old mean and the new sample, so the negative clamp never actually engages.
  assign diff_s   = $signed({1'b0, rsp_distance}) - $signed({1'b0, mean_q});
  assign step_s   = diff_s >>> ALPHA_SHIFT;
  assign sum_s    = $signed({1'b0, mean_q}) + step_s;
  assign mean_upd = sum_s[DIST_WIDTH] ? {DIST_WIDTH{1'b0}} : sum_s[DIST_WIDTH-1:0];

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      npts_q    <= '0;
      req_idx_q <= '0;
      rsp_cnt_q <= '0;
      credits_q <= '0;
      mean_q    <= '0;
      pruned_q  <= '0;
      tk_vld_q  <= 1'b0;
      tk_dist_q <= '0;
      tk_idx_q  <= '0;
      rd_sel_q  <= '0;
    end else begin
      state_q   <= state_d;
      npts_q    <= npts_d;
      req_idx_q <= req_idx_d;
      rsp_cnt_q <= rsp_cnt_d;
      credits_q <= credits_d;
      mean_q    <= mean_d;
      pruned_q  <= pruned_d;
      tk_vld_q  <= tk_vld_d;
      tk_dist_q <= tk_dist_d;
      tk_idx_q  <= tk_idx_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    npts_d    = npts_q;
    req_idx_d = req_idx_q;
    rsp_cnt_d = rsp_cnt_q;
    credits_d = credits_q;
    mean_d    = mean_q;
    pruned_d  = pruned_q;
    tk_vld_d  = 1'b0;
    tk_dist_d = tk_dist_q;
    tk_idx_d  = tk_idx_q;
    rd_sel_d  = rd_sel_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          npts_d  = num_points;
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CLEAR: begin
        req_idx_d = '0;
        rsp_cnt_d = '0;
        credits_d = CRED_W'(MAX_OUT);
        mean_d    = '0;
        pruned_d  = '0;
        rd_sel_d  = '0;
        state_d   = (npts_q == '0) ? S_DONE : S_STREAM;
      end

      S_STREAM: begin
        if (req_fire) begin
          req_idx_d = req_idx_q + IDX_WIDTH'(1);
        end else begin
          req_idx_d = req_idx_q;
        end
        case ({req_fire, rsp_fire})
          2'b10:   credits_d = credits_q - CRED_W'(1);
          2'b01:   credits_d = credits_q + CRED_W'(1);
          default: credits_d = credits_q;
        endcase
        if (rsp_fire) begin
          rsp_cnt_d = rsp_cnt_q + IDX_WIDTH'(1);
          mean_d    = (rsp_cnt_q == '0) ? rsp_distance : mean_upd;
          // Strictly-less compare: a distance equal to the threshold cannot improve the buffer.
          if (rsp_distance < threshold) begin
            tk_vld_d  = 1'b1;
            tk_dist_d = rsp_distance;
            tk_idx_d  = rsp_idx;
          end else begin
            pruned_d = pruned_q + IDX_WIDTH'(1);
          end
        end else begin
          rsp_cnt_d = rsp_cnt_q;
        end
        if (rsp_cnt_q == npts_q) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_STREAM;
        end
      end

      S_DRAIN: begin
        if (!topk_rd_vld) begin
          state_d = S_DONE;
        end else if (out_ready) begin
          if (rd_sel_q == SEL_W'(K - 1)) begin
            state_d = S_DONE;
          end else begin
            rd_sel_d = rd_sel_q + SEL_W'(1);
          end
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_knn_query_ctrl.sv
// Self-checking bench for knn_query_ctrl: models the distance unit and the top-K buffer,
// queues expected inserts and drain beats, and compares them as the DUT produces them.
module tb_knn_query_ctrl;
  localparam int DW = 16;
  localparam int IW = 16;
  localparam int K  = 8;
  localparam int SW = 3;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic [SW-1:0] r;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] num_points;
  logic          busy, done;
  logic          req_valid, req_ready;
  logic [IW-1:0] req_idx;
  logic          rsp_valid;
  logic [DW-1:0] rsp_distance;
  logic [IW-1:0] rsp_idx;
  logic          topk_clear, topk_valid;
  logic [DW-1:0] topk_dist;
  logic [IW-1:0] topk_idx;
  logic [DW-1:0] threshold;
  logic [DW-1:0] running_mean;
  logic [SW-1:0] topk_rd_sel;
  logic          topk_rd_vld;
  logic [DW-1:0] topk_rd_dist;
  logic [IW-1:0] topk_rd_idx;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_dist;
  logic [IW-1:0] out_idx;
  logic [SW-1:0] out_rank;
  logic [IW-1:0] pruned_cnt;

  // top-K buffer model and distance-unit model state
  logic          bv[K];
  logic [DW-1:0] bd[K];
  logic [IW-1:0] bi[K];
  logic [DW-1:0] dist_tab[16];
  logic [IW-1:0] pend[$];
  logic [31:0]   exp_ins[$];
  beat_t         exp_out[$];

  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, clear_cnt = 0, reqv_cnt = 0, outv_cnt = 0;
  int acc_cnt = 0, ins_cnt = 0, beats = 0, exp_pruned = 0;
  int rsp_budget = 0;
  int m_mean = 0, m_diff = 0;
  bit m_first = 1'b1;
  logic [IW-1:0] exp_req = '0;
  logic [IW-1:0] rv_idx;
  logic [31:0]   e_ins;
  beat_t         e_out;
  int            p_pos;

  always #5 clk = ~clk;

  assign topk_rd_vld  = bv[topk_rd_sel];
  assign topk_rd_dist = bd[topk_rd_sel];
  assign topk_rd_idx  = bi[topk_rd_sel];

  knn_query_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .num_points(num_points),
    .busy(busy), .done(done),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
    .rsp_valid(rsp_valid), .rsp_distance(rsp_distance), .rsp_idx(rsp_idx),
    .topk_clear(topk_clear), .topk_valid(topk_valid), .topk_dist(topk_dist), .topk_idx(topk_idx),
    .threshold(threshold), .running_mean(running_mean),
    .topk_rd_sel(topk_rd_sel), .topk_rd_vld(topk_rd_vld), .topk_rd_dist(topk_rd_dist),
    .topk_rd_idx(topk_rd_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist), .out_idx(out_idx),
    .out_rank(out_rank), .pruned_cnt(pruned_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic start_query(input int npts);
    @(posedge clk); #1;
    done_cnt = 0; clear_cnt = 0; reqv_cnt = 0; outv_cnt = 0;
    acc_cnt = 0; ins_cnt = 0; beats = 0; exp_pruned = 0;
    exp_req = '0; m_first = 1'b1; m_mean = 0;
    num_points = IW'(npts);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int n = 0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic push_beat(input int d, input int i, input int r);
    beat_t b;
    b.d = DW'(d); b.i = IW'(i); b.r = SW'(r);
    exp_out.push_back(b);
  endtask

  // Distance unit: returns one in-order response per cycle while budget allows
  initial begin
    rsp_valid = 1'b0; rsp_idx = '0; rsp_distance = '0;
    forever begin
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      if (reset === 1'b0 && rsp_budget > 0 && pend.size() > 0) begin
        rsp_budget--;
        rv_idx = pend.pop_front();
        rsp_valid = 1'b1;
        rsp_idx = rv_idx;
        rsp_distance = dist_tab[rv_idx[3:0]];
        if (rsp_distance < threshold) exp_ins.push_back({rsp_distance, rv_idx});
        else exp_pruned++;
        if (m_first) begin
          m_mean = int'(rsp_distance);
          m_first = 1'b0;
        end else begin
          m_diff = int'(rsp_distance) - m_mean;
          if (m_diff >= 0) m_mean = m_mean + m_diff / 8;
          else m_mean = m_mean - (-m_diff + 7) / 8;
        end
      end
    end
  end

  // Monitor: scoreboard compares, event counters and the top-K buffer model
  initial begin
    for (int j = 0; j < K; j++) begin
      bv[j] = 1'b0; bd[j] = '0; bi[j] = '0;
    end
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (done) done_cnt++;
        if (topk_clear) clear_cnt++;
        if (req_valid) reqv_cnt++;
        if (out_valid) outv_cnt++;
        if (req_valid && req_ready) begin
          check_eq("req_idx", req_idx, exp_req);
          exp_req = exp_req + IW'(1);
          pend.push_back(req_idx);
          acc_cnt++;
        end
        if (topk_valid) begin
          ins_cnt++;
          if (exp_ins.size() > 0) begin
            e_ins = exp_ins.pop_front();
            check_eq("ins_dist", topk_dist, e_ins[31:16]);
            check_eq("ins_idx", topk_idx, e_ins[15:0]);
          end
        end
        if (out_valid && out_ready) begin
          beats++;
          if (exp_out.size() > 0) begin
            e_out = exp_out.pop_front();
            check_eq("out_dist", out_dist, e_out.d);
            check_eq("out_idx", out_idx, e_out.i);
            check_eq("out_rank", out_rank, e_out.r);
          end
        end
        if (topk_clear) begin
          for (int j = 0; j < K; j++) bv[j] = 1'b0;
        end else if (topk_valid) begin
          p_pos = K;
          for (int j = K - 1; j >= 0; j--) if (!bv[j] || topk_dist < bd[j]) p_pos = j;
          if (p_pos < K) begin
            for (int j = K - 1; j > p_pos; j--) begin
              bv[j] = bv[j-1]; bd[j] = bd[j-1]; bi[j] = bi[j-1];
            end
            bv[p_pos] = 1'b1; bd[p_pos] = topk_dist; bi[p_pos] = topk_idx;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_points = '0; req_ready = 1'b1;
    out_ready = 1'b1; threshold = 16'hFFFF;
    for (int j = 0; j < 16; j++) dist_tab[j] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_req_valid", {31'd0, req_valid}, 32'd0);
    check_eq("rst_topk_valid", {31'd0, topk_valid}, 32'd0);
    check_eq("rst_topk_clear", {31'd0, topk_clear}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_mean", running_mean, 32'd0);
    check_eq("rst_pruned", pruned_cnt, 32'd0);
    check_eq("rst_rd_sel", topk_rd_sel, 32'd0);
    check_eq("rst_req_idx", req_idx, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Empty query
    rsp_budget = 1000;
    start_query(0);
    wait_done(20, "np0_done");
    check_eq("np0_done_cnt", done_cnt, 32'd1);
    check_eq("np0_clear_cnt", clear_cnt, 32'd1);
    check_eq("np0_req_valid", reqv_cnt, 32'd0);
    check_eq("np0_out_valid", outv_cnt, 32'd0);
    check_eq("np0_busy", {31'd0, busy}, 32'd0);

    // Five points, all inserted, drain held off for 10 cycles
    dist_tab[0] = 16'd50; dist_tab[1] = 16'd10; dist_tab[2] = 16'd40;
    dist_tab[3] = 16'd20; dist_tab[4] = 16'd30;
    push_beat(10, 1, 0); push_beat(20, 3, 1); push_beat(30, 4, 2);
    push_beat(40, 2, 3); push_beat(50, 0, 4);
    out_ready = 1'b0;
    start_query(5);
    for (int n = 0; n < 200 && !out_valid; n++) @(negedge clk);
    check_eq("drain_vld", {31'd0, out_valid}, 32'd1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check_eq("stall_vld", {31'd0, out_valid}, 32'd1);
      check_eq("stall_dist", out_dist, exp_out[0].d);
      check_eq("stall_idx", out_idx, exp_out[0].i);
      check_eq("stall_rank", out_rank, exp_out[0].r);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(100, "p5_done");
    check_eq("p5_beats", beats, 32'd5);
    check_eq("p5_inserts", ins_cnt, 32'd5);
    check_eq("p5_pruned", pruned_cnt, 32'd0);
    check_eq("p5_mean_model", running_mean, m_mean);
    check_eq("p5_mean", running_mean, 32'd39);
    check_eq("p5_done_cnt", done_cnt, 32'd1);
    check_eq("p5_leftover", exp_out.size(), 32'd0);

    // Credit limit: responses withheld
    for (int j = 0; j < 6; j++) begin
      dist_tab[j] = DW'(100 + j);
      push_beat(100 + j, j, j);
    end
    rsp_budget = 0;
    start_query(6);
    repeat (20) @(negedge clk);
    check_eq("cred_issued4", acc_cnt, 32'd4);
    check_eq("cred_req_low", {31'd0, req_valid}, 32'd0);
    rsp_budget = 1;
    repeat (10) @(negedge clk);
    check_eq("cred_issued5", acc_cnt, 32'd5);
    rsp_budget = 1000;
    wait_done(200, "cred_done");
    check_eq("cred_beats", beats, 32'd6);
    check_eq("cred_inserts", ins_cnt, 32'd6);

    // Threshold pre-filter, equality pruned
    threshold = 16'd25;
    dist_tab[0] = 16'd30; dist_tab[1] = 16'd25; dist_tab[2] = 16'd10;
    push_beat(10, 2, 0);
    start_query(3);
    wait_done(100, "thr_done");
    check_eq("thr_inserts", ins_cnt, 32'd1);
    check_eq("thr_pruned", pruned_cnt, 32'd2);
    check_eq("thr_pruned_model", pruned_cnt, exp_pruned);
    check_eq("thr_beats", beats, 32'd1);

    // Running mean 80 then 70
    threshold = 16'hFFFF;
    dist_tab[0] = 16'd80; dist_tab[1] = 16'd0;
    push_beat(0, 1, 0); push_beat(80, 0, 1);
    start_query(2);
    wait_done(100, "mean_done");
    check_eq("mean_70", running_mean, 32'd70);
    check_eq("mean_model", running_mean, m_mean);
    check_eq("mean_beats", beats, 32'd2);

    // Reset in the middle of streaming
    for (int j = 0; j < 8; j++) dist_tab[j] = 16'd80;
    rsp_budget = 2;
    start_query(8);
    repeat (12) @(negedge clk);
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_req_valid", {31'd0, req_valid}, 32'd0);
    check_eq("abort_mean", running_mean, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_budget = 0;
    pend.delete(); exp_ins.delete(); exp_out.delete();
    repeat (5) @(negedge clk);
    check_eq("abort_no_done", done_cnt, 32'd0);
    check_eq("abort_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
